rst_seq: RTL and testbench
==========================

# rst_seq

Parametrised reset sequencer, the successor to the single-output reset delay. It sits directly after the clock generator and drives every downstream reset in the clock domain. It holds all reset outputs asserted until the PLL `locked` signal has been stable for a programmable time, then releases N reset outputs one at a time in index order. It re-asserts all outputs on lock loss or on a software reset request.

## Interface
Parameters:
- `N_OUT`, default 4: number of reset outputs (1..16).
- `LOCK_FILTER`, default 8: cycles `locked_s` must stay high before release starts (>=1).
- `STAGE_DELAY`, default 8: cycles between successive output releases (>=1).
- `SW_HOLD`, default 16: cycles all outputs are held after a software reset request (>=1).

Ports:
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst_n`, in, 1: reset is synchronous and active-low.
- `locked`, in, 1: PLL lock, asynchronous to `clk`.
- `sw_rst`, in, 1: synchronous software reset request, active-high, level or pulse.
- `rst_out`, out, N_OUT: active-high resets, bit i released i-th; registered.
- `seq_done`, out, 1: high once all outputs are released; registered.
- `state`, out, 3: current FSM state, for debug.

## Operation
- `locked` passes through a 2-flop synchroniser; its output is `locked_s`.
- One counter `cnt`, width $clog2(max(LOCK_FILTER, STAGE_DELAY, SW_HOLD)+1). It saturates, never wraps.
- Stage index `stg`, width $clog2(N_OUT+1).

FSM states and transitions:
- HOLD (0): `rst_out` all 1, `seq_done`=0, `cnt`=0. If `locked_s`=1, go to FILTER.
- FILTER (1): `cnt`++ each cycle. If `cnt`==LOCK_FILTER-1, go to RELEASE with `cnt`=0 and `stg`=0.
- RELEASE (2): `cnt`++. If `cnt`==STAGE_DELAY-1, clear `rst_out[stg]`, set `cnt`=0, `stg`++. Releasing bit N_OUT-1 moves to RUN and sets `seq_done`=1 on the same edge.
- RUN (3): `rst_out` all 0, `seq_done`=1.
- SWHOLD (4): `rst_out` all 1, `seq_done`=0, `cnt`++. If `cnt`==SW_HOLD-1, go to RELEASE with `cnt`=0 and `stg`=0. The FILTER state is skipped because lock is already stable.

Priorities, evaluated every cycle:
1. `rst_n`=0. All registers reset: state HOLD, `rst_out` all 1, `seq_done` 0, synchroniser flops 0, `cnt`=0, `stg`=0.
2. `locked_s`=0 in any state. Go to HOLD; `rst_out` all 1 and `seq_done` 0 on the next edge. This aborts FILTER, RELEASE and SWHOLD.
3. `sw_rst`=1 in RELEASE, RUN or SWHOLD. Go to SWHOLD with `cnt`=0; all outputs re-asserted on the next edge. In SWHOLD, a held `sw_rst` keeps restarting the count.
4. `sw_rst` is ignored in HOLD and FILTER, where all outputs are already asserted.

Invariants:
- A released bit never re-asserts except through priority 1, 2 or 3, and then all bits re-assert together.
- `rst_out[i]`=0 implies `rst_out[j]`=0 for all j<i.
- No illegal state encodings are reachable. States 5-7 decode to HOLD.

## Timing
- Reset values: `rst_out`={N_OUT{1}}, `seq_done`=0, `state`=0.
- Let E0 be the first edge with `locked`=1 and `rst_n`=1. Then `locked_s`=1 after E1, FILTER is entered at E2, and RELEASE at E(2+LOCK_FILTER).
- `rst_out[i]` falls at E(2+LOCK_FILTER+(i+1)·STAGE_DELAY).
- `seq_done` rises on the same edge as `rst_out[N_OUT-1]` falls.
- Lock loss: if `locked` is low at edge E0, `rst_out` is all 1 after E2 (2 synchroniser cycles + 1 register).
- Software reset: if `sw_rst` is sampled at E0, `rst_out` is all 1 after E0. `rst_out[0]` falls at E(SW_HOLD+STAGE_DELAY).
- A `locked` glitch shorter than LOCK_FILTER cycles, once synchronised, causes no release.

## Test plan
- Defaults; `rst_n` low for 3 cycles, then `locked` high at E0 → `rst_out` falls bit-by-bit at E18, E26, E34, E42; `seq_done` rises at E42.
- `locked` high for 5 cycles then low, repeated 3 times → `rst_out` stays 4'b1111 and `state` never reaches RELEASE.
- `locked` drops at E30 of a sequence (bits 0-1 released) → `rst_out`=4'b1111 after E32. On re-lock, the full sequence restarts with the filter.
- In RUN, 1-cycle `sw_rst` at E0 → `rst_out`=4'b1111 after E0, bit 0 falls at E24, `seq_done` rises at E48.
- `sw_rst` and lock loss in the same cycle → state HOLD (lock loss wins); no release until LOCK_FILTER expires after re-lock.
- N_OUT=1, LOCK_FILTER=1, STAGE_DELAY=1 → `rst_out` falls at E4, with `seq_done` high on the same edge. `rst_n` low mid-RELEASE → all reset values on the next edge.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer for one clock domain.
// Holds every downstream reset asserted until the PLL lock has been stable
// for LOCK_FILTER cycles, then releases the outputs one by one in index
// order, STAGE_DELAY cycles apart. Lock loss or a software request puts all
// outputs back into reset together.
module rst_seq #(
    parameter int N_OUT       = 4,
    parameter int LOCK_FILTER = 8,
    parameter int STAGE_DELAY = 8,
    parameter int SW_HOLD     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             locked,
    input  logic             sw_rst,
    output logic [N_OUT-1:0] rst_out,
    output logic             seq_done,
    output logic [2:0]       state
);

    // One shared counter serves all three timed phases, so it is sized
    // for the longest of them.
    localparam int MAX_A = (LOCK_FILTER > STAGE_DELAY) ? LOCK_FILTER : STAGE_DELAY;
    localparam int MAX_C = (MAX_A > SW_HOLD) ? MAX_A : SW_HOLD;
    localparam int CW    = $clog2(MAX_C + 1);
    localparam int STW   = $clog2(N_OUT + 1);

    localparam logic [CW-1:0]  CNT_MAX   = '1;
    localparam logic [CW-1:0]  FILT_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0]  STG_LAST  = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0]  SW_LAST   = CW'(SW_HOLD - 1);
    localparam logic [STW-1:0] LAST_BIT  = STW'(N_OUT - 1);

    typedef enum logic [2:0] {
        HOLD    = 3'd0,
        FILTER  = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        SWHOLD  = 3'd4
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic   [CW-1:0]    cnt_q;
    logic   [CW-1:0]    cnt_nxt;
    logic   [CW-1:0]    cnt_inc;
    logic   [STW-1:0]   stg_q;
    logic   [STW-1:0]   stg_nxt;
    logic   [N_OUT-1:0] rst_nxt;
    logic               done_nxt;
    logic               sync_q;
    logic               locked_s;

    assign state   = state_q;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Two-flop synchroniser bringing the asynchronous PLL lock into clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= locked;
            locked_s <= sync_q;
        end
    end

    // State, counter, stage index and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= HOLD;
            cnt_q    <= '0;
            stg_q    <= '0;
            rst_out  <= '1;
            seq_done <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            cnt_q    <= cnt_nxt;
            stg_q    <= stg_nxt;
            rst_out  <= rst_nxt;
            seq_done <= done_nxt;
        end
    end

    // Next-state logic: lock loss beats a software request, which beats
    // the normal timed progression.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        stg_nxt   = stg_q;
        if (!locked_s) begin
            state_nxt = HOLD;
            cnt_nxt   = '0;
            stg_nxt   = '0;
        end else if (sw_rst && (state_q == RELEASE || state_q == RUN || state_q == SWHOLD)) begin
            state_nxt = SWHOLD;
            cnt_nxt   = '0;
            stg_nxt   = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    state_nxt = FILTER;
                    cnt_nxt   = '0;
                    stg_nxt   = '0;
                end
                FILTER: begin
                    if (cnt_q == FILT_LAST) begin
                        state_nxt = RELEASE;
                        cnt_nxt   = '0;
                        stg_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                RELEASE: begin
                    if (cnt_q == STG_LAST) begin
                        cnt_nxt = '0;
                        stg_nxt = stg_q + 1'b1;
                        if (stg_q == LAST_BIT) begin
                            state_nxt = RUN;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                RUN: begin
                    cnt_nxt = '0;
                end
                SWHOLD: begin
                    if (cnt_q == SW_LAST) begin
                        state_nxt = RELEASE;
                        cnt_nxt   = '0;
                        stg_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                    stg_nxt   = '0;
                end
            endcase
        end
    end

    // Output decode from the upcoming state: bits below the stage index are
    // released, which keeps the release order monotonic by construction.
    always_comb begin
        rst_nxt  = '1;
        done_nxt = 1'b0;
        case (state_nxt)
            RUN: begin
                rst_nxt  = '0;
                done_nxt = 1'b1;
            end
            RELEASE: begin
                for (int j = 0; j < N_OUT; j++) begin
                    rst_nxt[j] = (STW'(j) >= stg_nxt);
                end
            end
            default: begin
                rst_nxt  = '1;
                done_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: self-checking bench for rst_seq. A timeline model (phase plus
// cycles elapsed since the phase began) predicts outputs every cycle; some
// scenarios also check absolute edge numbers from the documented timing.
module tb_rst_seq;

    localparam int N  = 4;
    localparam int LF = 8;
    localparam int SD = 8;
    localparam int SH = 16;

    localparam int M_IDLE = 0;
    localparam int M_LOCK = 1;
    localparam int M_SW   = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         locked = 1'b0;
    logic         sw_rst = 1'b0;
    logic [N-1:0] rst_out;
    logic         seq_done;
    logic [2:0]   state;

    logic         rst_n2 = 1'b0;
    logic         locked2 = 1'b0;
    logic         sw_rst2 = 1'b0;
    logic [0:0]   rst_out2;
    logic         seq_done2;
    logic [2:0]   state2;

    int errors = 0;
    int checks = 0;

    int m_mode = M_IDLE;
    int m_t = 0;
    logic m_s1 = 1'b0;
    logic m_s2 = 1'b0;
    logic [N-1:0] exp_rst;
    logic         exp_done;
    logic [2:0]   exp_state;

    always #5 clk = ~clk;

    rst_seq #(.N_OUT(N), .LOCK_FILTER(LF), .STAGE_DELAY(SD), .SW_HOLD(SH)) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .sw_rst(sw_rst),
        .rst_out(rst_out), .seq_done(seq_done), .state(state)
    );

    rst_seq #(.N_OUT(1), .LOCK_FILTER(1), .STAGE_DELAY(1), .SW_HOLD(16)) dut_small (
        .clk(clk), .rst_n(rst_n2), .locked(locked2), .sw_rst(sw_rst2),
        .rst_out(rst_out2), .seq_done(seq_done2), .state(state2)
    );

    // Translate the current phase and elapsed time into expected outputs.
    task automatic model_expect();
        int k;
        logic [N-1:0] ones;
        ones = '1;
        exp_rst = '1; exp_done = 1'b0; exp_state = 3'd0;
        k = -1;
        if (m_mode == M_LOCK) begin
            if (m_t < LF) exp_state = 3'd1;
            else k = (m_t - LF) / SD;
        end else if (m_mode == M_SW) begin
            if (m_t < SH) exp_state = 3'd4;
            else k = (m_t - SH) / SD;
        end
        if (k >= N) begin
            exp_rst = '0; exp_done = 1'b1; exp_state = 3'd3;
        end else if (k >= 0) begin
            exp_rst = ones << k; exp_state = 3'd2;
        end
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_update();
        logic ls;
        if (!rst_n) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_mode = M_IDLE; m_t = 0;
        end else begin
            ls = m_s2; m_s2 = m_s1; m_s1 = locked;
            if (!ls) begin
                m_mode = M_IDLE; m_t = 0;
            end else if (sw_rst && (m_mode == M_SW || (m_mode == M_LOCK && m_t >= LF))) begin
                m_mode = M_SW; m_t = 0;
            end else if (m_mode == M_IDLE) begin
                m_mode = M_LOCK; m_t = 0;
            end else if (m_t < 100000) begin
                m_t++;
            end
        end
        model_expect();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; locked = 1'b0; sw_rst = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; locked = 1'b1; sw_rst = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if (rst_out !== 4'hF || seq_done !== 1'b0 || state !== 3'd0) begin
                errors++;
                $display("[TB] FAIL reset rst_out=%b/1111 seq_done=%b/0 state=%0d/0", rst_out, seq_done, state);
            end
        end
        locked = 1'b0; sw_rst = 1'b0;
    endtask

    task automatic test_nominal();
        do_reset();
        locked = 1'b1;
        for (int e = 0; e <= 46; e++) begin
            step();
            checks++;
            if (rst_out !== exp_rst || seq_done !== exp_done || state !== exp_state) begin
                errors++;
                $display("[TB] FAIL nominal_model E%0d rst_out=%b/%b seq_done=%b/%b state=%0d/%0d",
                         e, rst_out, exp_rst, seq_done, exp_done, state, exp_state);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (rst_out[i] !== ((e >= 2 + LF + (i + 1) * SD) ? 1'b0 : 1'b1)) begin
                    errors++;
                    $display("[TB] FAIL nominal_bit%0d E%0d got=%b", i, e, rst_out[i]);
                end
            end
            checks++;
            if (seq_done !== (e >= 42)) begin
                errors++;
                $display("[TB] FAIL nominal_done E%0d got=%b want=%b", e, seq_done, e >= 42);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        repeat (3) begin
            for (int c = 0; c < 10; c++) begin
                locked = (c < 5);
                step();
                checks++;
                if (rst_out !== 4'hF || state === 3'd2 || rst_out !== exp_rst || state !== exp_state) begin
                    errors++;
                    $display("[TB] FAIL glitch rst_out=%b/1111 state=%0d/%0d", rst_out, state, exp_state);
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        locked = 1'b1;
        for (int e = 0; e <= 40; e++) begin
            if (e == 30) locked = 1'b0;
            step();
            checks++;
            if (rst_out !== exp_rst || seq_done !== exp_done || state !== exp_state) begin
                errors++;
                $display("[TB] FAIL lockloss_model E%0d rst_out=%b/%b state=%0d/%0d", e, rst_out, exp_rst, state, exp_state);
            end
            if (e == 31) begin
                checks++;
                if (rst_out !== 4'b1100) begin
                    errors++;
                    $display("[TB] FAIL lockloss_E31 rst_out=%b/1100", rst_out);
                end
            end
            if (e == 32) begin
                checks++;
                if (rst_out !== 4'hF || seq_done !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL lockloss_E32 rst_out=%b/1111 seq_done=%b/0", rst_out, seq_done);
                end
            end
        end
        locked = 1'b1;
        for (int r = 0; r <= 20; r++) begin
            step();
            checks++;
            if (rst_out[0] !== ((r >= 18) ? 1'b0 : 1'b1) || rst_out !== exp_rst) begin
                errors++;
                $display("[TB] FAIL relock R%0d rst_out=%b/%b", r, rst_out, exp_rst);
            end
        end
    endtask

    task automatic test_sw_rst();
        do_reset();
        locked = 1'b1;
        repeat (45) step();
        checks++;
        if (state !== 3'd3 || seq_done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sw_pre_run state=%0d/3 seq_done=%b/1", state, seq_done);
        end
        sw_rst = 1'b1;
        for (int e = 0; e <= 50; e++) begin
            step();
            sw_rst = 1'b0;
            checks++;
            if (rst_out !== exp_rst || seq_done !== exp_done || state !== exp_state) begin
                errors++;
                $display("[TB] FAIL sw_model E%0d rst_out=%b/%b state=%0d/%0d", e, rst_out, exp_rst, state, exp_state);
            end
            checks++;
            if (rst_out[0] !== ((e >= SH + SD) ? 1'b0 : 1'b1) || seq_done !== (e >= 48)
                || (e == 0 && rst_out !== 4'hF)) begin
                errors++;
                $display("[TB] FAIL sw_timing E%0d rst_out=%b seq_done=%b", e, rst_out, seq_done);
            end
        end
        // A held request keeps the outputs in reset until it goes away.
        sw_rst = 1'b1;
        for (int e = 0; e < 50; e++) begin
            if (e == 20) sw_rst = 1'b0;
            step();
            checks++;
            if (rst_out !== exp_rst || state !== exp_state) begin
                errors++;
                $display("[TB] FAIL sw_held E%0d rst_out=%b/%b state=%0d/%0d", e, rst_out, exp_rst, state, exp_state);
            end
        end
    endtask

    task automatic test_sw_and_lock_loss();
        do_reset();
        locked = 1'b1;
        repeat (45) step();
        locked = 1'b0;
        step();
        step();
        sw_rst = 1'b1;
        step();
        checks++;
        if (state !== 3'd0 || rst_out !== 4'hF) begin
            errors++;
            $display("[TB] FAIL sw_vs_lockloss state=%0d/0 rst_out=%b/1111", state, rst_out);
        end
        repeat (3) step();
        locked = 1'b1;
        for (int r = 0; r <= 20; r++) begin
            if (r == 8) sw_rst = 1'b0;
            step();
            checks++;
            if (rst_out !== exp_rst || state !== exp_state
                || rst_out[0] !== ((r >= 18) ? 1'b0 : 1'b1) || (state === 3'd2) !== (r >= 10)) begin
                errors++;
                $display("[TB] FAIL sw_lock_relock R%0d rst_out=%b/%b state=%0d/%0d", r, rst_out, exp_rst, state, exp_state);
            end
        end
        sw_rst = 1'b0;
    endtask

    task automatic test_reset_mid_release();
        do_reset();
        locked = 1'b1;
        repeat (21) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (rst_out !== 4'hF || seq_done !== 1'b0 || state !== 3'd0) begin
            errors++;
            $display("[TB] FAIL midrelease_reset rst_out=%b/1111 seq_done=%b/0 state=%0d/0", rst_out, seq_done, state);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_small_config();
        rst_n2 = 1'b0; locked2 = 1'b0; sw_rst2 = 1'b0;
        repeat (2) step();
        rst_n2 = 1'b1; locked2 = 1'b1;
        for (int e = 0; e <= 6; e++) begin
            step();
            checks++;
            if (rst_out2 !== ((e >= 4) ? 1'b0 : 1'b1) || seq_done2 !== (e >= 4)) begin
                errors++;
                $display("[TB] FAIL small_release E%0d rst_out=%b seq_done=%b", e, rst_out2, seq_done2);
            end
        end
        rst_n2 = 1'b0;
        repeat (2) step();
        rst_n2 = 1'b1;
        repeat (4) step();
        checks++;
        if (state2 !== 3'd2) begin
            errors++;
            $display("[TB] FAIL small_in_release state=%0d/2", state2);
        end
        rst_n2 = 1'b0;
        step();
        checks++;
        if (rst_out2 !== 1'b1 || seq_done2 !== 1'b0 || state2 !== 3'd0) begin
            errors++;
            $display("[TB] FAIL small_reset rst_out=%b/1 seq_done=%b/0 state=%0d/0", rst_out2, seq_done2, state2);
        end
    endtask

    task automatic test_random();
        do_reset();
        locked = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 59) == 0) locked = ~locked;
            sw_rst = ($urandom_range(0, 79) == 0);
            rst_n  = ($urandom_range(0, 299) != 0);
            step();
            checks++;
            if (rst_out !== exp_rst || seq_done !== exp_done || state !== exp_state) begin
                errors++;
                $display("[TB] FAIL random c=%0d rst_out=%b/%b seq_done=%b/%b state=%0d/%0d",
                         c, rst_out, exp_rst, seq_done, exp_done, state, exp_state);
            end
        end
        rst_n = 1'b1; sw_rst = 1'b0;
    endtask

    initial begin
        model_expect();
        test_reset();
        test_nominal();
        test_glitch();
        test_lock_loss();
        test_sw_rst();
        test_sw_and_lock_loss();
        test_reset_mid_release();
        test_small_config();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
